alu16_cmd_driver: RTL and testbench

- Initiator side of the 16-bit ALU interface: accepts (a, b, op) commands over a valid/ready handshake and buffers them in a small FIFO.
- Drives each command onto the combinational ALU's operand/op inputs, waits a fixed settle time, then captures the ALU sum.
- Returns each result over a valid/ready response channel.
- Replaces hand-timed bench stimulus with a clocked, back-pressured driver usable from a control FSM or a BIST.

---
 rtl/alu16_cmd_driver.sv | 216 +++++++++++++++++++++
 tb/tb_alu16_cmd_driver.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu16_cmd_driver.sv
// alu16_cmd_driver: FIFO-buffered valid/ready command driver for a combinational ALU.
// Optional macro ALU_DRV_OP_CHECK_EN adds rsp_err and rejects unimplemented opcode 3'b010.
module alu16_cmd_driver #(
  parameter int WIDTH         = 16,
  parameter int OP_W          = 3,
  parameter int FIFO_DEPTH    = 4,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [WIDTH-1:0]            cmd_a,
  input  logic [WIDTH-1:0]            cmd_b,
  input  logic [OP_W-1:0]             cmd_op,
  output logic [WIDTH-1:0]            alu_a,
  output logic [WIDTH-1:0]            alu_b,
  output logic [OP_W-1:0]             alu_op,
  input  logic [WIDTH-1:0]            alu_sum,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [WIDTH-1:0]            rsp_sum,
  output logic [OP_W-1:0]             rsp_op,
`ifdef ALU_DRV_OP_CHECK_EN
  output logic                        rsp_err,
`endif
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = 2 * WIDTH + OP_W;
  localparam int SW = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    RESP
  } state_e;

  state_e            state_q, state_d;
  logic [EW-1:0]     mem_q [FIFO_DEPTH];
  logic [EW-1:0]     mem_d [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [WIDTH-1:0]  alu_a_q, alu_a_d;
  logic [WIDTH-1:0]  alu_b_q, alu_b_d;
  logic [OP_W-1:0]   alu_op_q, alu_op_d;
  logic [SW-1:0]     settle_q, settle_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0]  rsp_sum_q, rsp_sum_d;
  logic [OP_W-1:0]   rsp_op_q, rsp_op_d;
`ifdef ALU_DRV_OP_CHECK_EN
  logic              rsp_err_q, rsp_err_d;
`endif

  logic              fifo_empty;
  logic              push;
  logic              pop;
  logic              hs;
  logic              bad_op;
  logic [EW-1:0]     head;
  logic [WIDTH-1:0]  head_a;
  logic [WIDTH-1:0]  head_b;
  logic [OP_W-1:0]   head_op;

  assign fifo_empty = (count_q == '0);
  assign cmd_ready  = (count_q != CW'(FIFO_DEPTH));
  assign push       = cmd_valid & cmd_ready;
  assign hs         = rsp_valid_q & rsp_ready;
  assign pop        = ~fifo_empty &
                      ((state_q == IDLE) | ((state_q == RESP) & hs));
  assign head       = mem_q[rd_ptr_q];
  assign head_a     = head[EW-1 -: WIDTH];
  assign head_b     = head[EW-WIDTH-1 -: WIDTH];
  assign head_op    = head[OP_W-1:0];

`ifdef ALU_DRV_OP_CHECK_EN
  assign bad_op     = (head_op == OP_W'(2));
`else
  assign bad_op     = 1'b0;
`endif

  // command FIFO: storage, pointers and occupancy
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = {cmd_a, cmd_b, cmd_op};
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    count_d = count_q + CW'(push) - CW'(pop);
  end

  // FSM next state: a rejected opcode skips SETTLE entirely
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (pop) state_d = bad_op ? RESP : SETTLE;
      end
      SETTLE: begin
        if (settle_q == SW'(1)) state_d = RESP;
      end
      RESP: begin
        if (hs) begin
          if (pop) state_d = bad_op ? RESP : SETTLE;
          else     state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: ALU operand launch, settle timer, response capture
  always_comb begin
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_op_d    = alu_op_q;
    settle_d    = settle_q;
    rsp_valid_d = rsp_valid_q;
    rsp_sum_d   = rsp_sum_q;
    rsp_op_d    = rsp_op_q;
`ifdef ALU_DRV_OP_CHECK_EN
    rsp_err_d   = rsp_err_q;
`endif
    if (state_q == SETTLE) begin
      settle_d = settle_q - SW'(1);
      if (settle_q == SW'(1)) begin
        rsp_valid_d = 1'b1;
        rsp_sum_d   = alu_sum;
        rsp_op_d    = alu_op_q;
`ifdef ALU_DRV_OP_CHECK_EN
        rsp_err_d   = 1'b0;
`endif
      end
    end
    if (hs) begin
      rsp_valid_d = 1'b0;
    end
    if (pop) begin
      if (bad_op) begin
        rsp_valid_d = 1'b1;
        rsp_sum_d   = '0;
        rsp_op_d    = head_op;
`ifdef ALU_DRV_OP_CHECK_EN
        rsp_err_d   = 1'b1;
`endif
      end else begin
        alu_a_d  = head_a;
        alu_b_d  = head_b;
        alu_op_d = head_op;
        settle_d = SW'(SETTLE_CYCLES);
      end
    end
  end

  // FIFO storage needs no reset: entries are only read after being written
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // state register with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= '0;
      settle_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_sum_q   <= '0;
      rsp_op_q    <= '0;
`ifdef ALU_DRV_OP_CHECK_EN
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_op_q    <= alu_op_d;
      settle_q    <= settle_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_sum_q   <= rsp_sum_d;
      rsp_op_q    <= rsp_op_d;
`ifdef ALU_DRV_OP_CHECK_EN
      rsp_err_q   <= rsp_err_d;
`endif
    end
  end

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_op     = alu_op_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_sum    = rsp_sum_q;
  assign rsp_op     = rsp_op_q;
`ifdef ALU_DRV_OP_CHECK_EN
  assign rsp_err    = rsp_err_q;
`endif
  assign busy       = (state_q != IDLE) | ~fifo_empty;
  assign fifo_count = count_q;

endmodule

// File: tb/tb_alu16_cmd_driver.sv
// tb_alu16_cmd_driver: scoreboard bench for alu16_cmd_driver.
// Honours ALU_DRV_OP_CHECK_EN when the design is built with it.
module tb_alu16_cmd_driver;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_a;
  logic [15:0] cmd_b;
  logic [2:0]  cmd_op;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [2:0]  alu_op;
  logic [15:0] alu_sum;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_sum;
  logic [2:0]  rsp_op;
  logic        busy;
  logic [2:0]  fifo_count;
`ifdef ALU_DRV_OP_CHECK_EN
  logic        rsp_err;
`endif

  alu16_cmd_driver dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .cmd_op     (cmd_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_sum    (alu_sum),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_sum    (rsp_sum),
    .rsp_op     (rsp_op),
`ifdef ALU_DRV_OP_CHECK_EN
    .rsp_err    (rsp_err),
`endif
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  // ALU stub from the test plan
  assign alu_sum = (alu_a + alu_b) ^ {13'b0, alu_op};

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] sum;
    logic [2:0]  op;
    logic        err;
  } exp_t;

  exp_t        sbq[$];
  int          hs_cyc[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          acc_cnt = 0;
  int          rsp_cnt = 0;
  int          last_acc_edge = 0;
  int          last_rise = 0;
  logic        pv = 1'b0;
  logic [15:0] last_sum = '0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                 input logic [2:0] op);
    exp_t        e;
    int unsigned s;
    s = (32'(a) + 32'(b)) % 65536;
    s = s ^ 32'(op);
    e.sum = 16'(s);
    e.op  = op;
    e.err = 1'b0;
`ifdef ALU_DRV_OP_CHECK_EN
    if (op == 3'd2) begin
      e.sum = 16'h0000;
      e.err = 1'b1;
    end
`endif
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    total++;
    bad++;
    $display("FAIL %s", nm);
  endtask

  // accept tracker and response monitor; handshakes complete on the next posedge
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (cmd_valid && cmd_ready) begin
        sbq.push_back(model(cmd_a, cmd_b, cmd_op));
        acc_cnt++;
        last_acc_edge = cyc + 1;
      end
      if (rsp_valid && !pv) last_rise = cyc;
      if (rsp_valid && rsp_ready) begin
        rsp_cnt++;
        hs_cyc.push_back(cyc);
        last_sum = rsp_sum;
        if (sbq.size() == 0) begin
          fail_now("unexpected_rsp");
        end else begin
          e = sbq.pop_front();
          chk("rsp_sum", 32'(rsp_sum), 32'(e.sum));
          chk("rsp_op", 32'(rsp_op), 32'(e.op));
`ifdef ALU_DRV_OP_CHECK_EN
          chk("rsp_err", 32'(rsp_err), 32'(e.err));
`endif
        end
      end
    end
    pv = reset ? 1'b0 : rsp_valid;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] a, input logic [15:0] b,
                      input logic [2:0] op);
    int n;
    cmd_a = a;
    cmd_b = b;
    cmd_op = op;
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 200) begin
      step();
      n++;
    end
    if (!cmd_ready) fail_now("send_timeout");
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((sbq.size() != 0 || busy || rsp_valid) && n < 1000) begin
      step();
      n++;
    end
    if (n >= 1000) fail_now("drain_timeout");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  ops3 [6];
    logic [15:0] s0;
    int          n;
    int          base;
    logic        acc;
    ops3 = '{3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};

    reset = 1'b1;
    cmd_valid = 1'b0;
    cmd_a = '0;
    cmd_b = '0;
    cmd_op = '0;
    rsp_ready = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_alu_a", 32'(alu_a), 32'd0);
    chk("rst_fifo_count", 32'(fifo_count), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rsp_sum", 32'(rsp_sum), 32'd0);

    // 1: basic command and latency
    rsp_ready = 1'b1;
    send(16'h0003, 16'h0001, 3'd0);
    wait_idle();
    chk("latency", 32'(last_rise - last_acc_edge), 32'd2);
    chk("t1_sum", 32'(last_sum), 32'h0004);

    // 2: backpressure hold
    rsp_ready = 1'b0;
    send(16'hF803, 16'hFFFF, 3'd1);
    n = 0;
    while (!rsp_valid && n < 20) begin
      step();
      n++;
    end
    chk("t2_valid", 32'(rsp_valid), 32'd1);
    chk("t2_sum", 32'(rsp_sum), 32'hF803);
    s0 = rsp_sum;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_valid", 32'(rsp_valid), 32'd1);
      chk("hold_sum", 32'(rsp_sum), 32'(s0));
      chk("hold_alu_a", 32'(alu_a), 32'hF803);
    end
    rsp_ready = 1'b1;
    wait_idle();

    // 3: fill the FIFO under backpressure
    rsp_ready = 1'b0;
    base = rsp_cnt;
    for (int i = 0; i < 5; i++) begin
      send(16'($urandom), 16'($urandom), ops3[i]);
    end
    step();
    chk("full_count", 32'(fifo_count), 32'd4);
    chk("full_ready", 32'(cmd_ready), 32'd0);
    n = acc_cnt;
    cmd_a = 16'($urandom);
    cmd_b = 16'($urandom);
    cmd_op = ops3[5];
    cmd_valid = 1'b1;
    repeat (3) step();
    chk("full_no_push", 32'(acc_cnt - n), 32'd0);
    chk("full_count2", 32'(fifo_count), 32'd4);
    rsp_ready = 1'b1;
    send(cmd_a, cmd_b, cmd_op);
    wait_idle();
    chk("t3_rsp_cnt", 32'(rsp_cnt - base), 32'd6);

    // 4: back-to-back spacing
    hs_cyc.delete();
    for (int i = 0; i < 3; i++) begin
      send(16'($urandom), 16'($urandom), 3'($urandom_range(0, 7)));
    end
    wait_idle();
    chk("b2b_n", 32'(hs_cyc.size()), 32'd3);
    if (hs_cyc.size() == 3) begin
      chk("b2b_gap0", 32'(hs_cyc[1] - hs_cyc[0]), 32'd2);
      chk("b2b_gap1", 32'(hs_cyc[2] - hs_cyc[1]), 32'd2);
    end

    // 5: reset in SETTLE with two commands queued
    for (int i = 0; i < 4; i++) begin
      send(16'($urandom), 16'($urandom), 3'd1);
    end
    chk("pre_rst_count", 32'(fifo_count), 32'd2);
    chk("pre_rst_valid", 32'(rsp_valid), 32'd0);
    reset = 1'b1;
    sbq.delete();
    step();
    reset = 1'b0;
    chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_count", 32'(fifo_count), 32'd0);
    chk("mid_rst_alu_a", 32'(alu_a), 32'd0);
    chk("mid_rst_alu_b", 32'(alu_b), 32'd0);
    chk("mid_rst_alu_op", 32'(alu_op), 32'd0);
    chk("mid_rst_ready", 32'(cmd_ready), 32'd1);
    base = rsp_cnt;
    repeat (10) step();
    chk("no_stale_rsp", 32'(rsp_cnt - base), 32'd0);
    chk("post_rst_busy", 32'(busy), 32'd0);

    // 6: opcode 3'b010
    send(16'h1234, 16'h1111, 3'd0);
    wait_idle();
    send(16'h0003, 16'h0001, 3'd2);
    wait_idle();
`ifdef ALU_DRV_OP_CHECK_EN
    chk("op2_sum", 32'(last_sum), 32'h0000);
    chk("op2_alu_a", 32'(alu_a), 32'h1234);
    chk("op2_alu_op", 32'(alu_op), 32'd0);
`else
    chk("op2_sum", 32'(last_sum), 32'h0006);
    chk("op2_alu_a", 32'(alu_a), 32'h0003);
    chk("op2_alu_op", 32'(alu_op), 32'd2);
`endif

    // 7: random traffic with random backpressure
    for (int i = 0; i < 600; i++) begin
      acc = cmd_valid && cmd_ready;
      if (!cmd_valid || acc) begin
        cmd_valid = 1'($urandom);
        cmd_a = 16'($urandom);
        cmd_b = 16'($urandom);
        cmd_op = 3'($urandom);
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    wait_idle();
    chk("final_sbq_empty", 32'(sbq.size()), 32'd0);
    chk("final_count", 32'(fifo_count), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
